load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- CPU-side initiator for the 1024-byte, big-endian, 64-bit data memory.
- Accepts byte/half/word/double load and store requests over a valid/ready handshake and drives the memory's mem_read/mem_write/address/data port.
- Performs big-endian lane extraction and sign/zero extension on loads, and read-modify-write on sub-doubleword stores.
- Sits between the execute stage and data memory.

Parameters:
- MEM_BYTES, 1024, addressable bytes; any address >= MEM_BYTES is an error.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; equals (state==IDLE)
- req_store  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=double
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified (byte uses [7:0], half [15:0], word [31:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or out-of-range request
- mem_address  out  64  aligned doubleword address to memory
- mem_write_data  out  64  doubleword to memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_read_data  in  64  combinational memory read data

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
  - Latched request fields cleared.
- States: IDLE, LOAD, STORE_WR, RMW_RD, RMW_WR, RESP.
- IDLE: on req_valid at a rising edge (cycle T), latch req_store, req_size, req_unsigned, req_addr and req_wdata. Next state:
  - error -> RESP with resp_error=1
  - load -> LOAD
  - store, size 11 -> STORE_WR
  - store, size < 11 -> RMW_RD
- Error conditions (checked in the accept cycle):
  - misaligned: addr not a multiple of 2^size.
  - out of range: addr >= MEM_BYTES.
  - On error: no memory strobe is ever issued; resp_rdata=0.
- Memory addressing:
  - mem_address = {latched_addr[63:3], 3'b000} in LOAD, STORE_WR, RMW_RD and RMW_WR; 0 otherwise.
  - Big-endian lanes: byte at offset k = addr[2:0] is bits [63-8k -: 8]. Half/word occupy 2/4 consecutive lanes starting at k.
  - Natural alignment guarantees an access never crosses a doubleword.
- LOAD (1 cycle): mem_read=1. Extract the lanes from mem_read_data, extend per req_unsigned (double: no extension), register into resp_rdata, then go to RESP.
- STORE_WR (1 cycle): mem_write=1, mem_write_data=req_wdata, then go to RESP.
- RMW_RD (1 cycle): mem_read=1. Capture mem_read_data with the target lanes replaced by the low bytes of wdata (MSB of the field in lane k), then go to RMW_WR.
- RMW_WR (1 cycle): mem_write=1, mem_write_data=merged doubleword, then go to RESP.
- Strobe rules:
  - mem_read and mem_write are never both 1.
  - Each strobe is asserted exactly one cycle per request.
  - mem_write_data=0 when mem_write=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_error held stable until resp_ready=1 at an edge, then go to IDLE.
  - resp_valid drops the cycle after the handshake.
  - No new request is accepted in the same cycle as the response handshake.
- Latency from accept edge T to first resp_valid cycle:
  - error: T+1
  - load or double store: T+2
  - sub-double store: T+3
- Reset mid-operation: abort immediately; all strobes drop asynchronously; a write not yet issued is never issued; the pending response is discarded.

Test Plan:
1. Store double 0x0123456789ABCDEF at 0x10, then load double at 0x10 -> resp_rdata 0x0123456789ABCDEF, resp_error=0, response at T+2.
2. After test 1, check extraction and extension:
   - load byte unsigned at 0x10 -> 0x0000000000000001
   - load byte signed at 0x17 -> 0xFFFFFFFFFFFFFFEF
   - load half signed at 0x14 -> 0xFFFFFFFFFFFF89AB
   - load word unsigned at 0x14 -> 0x0000000089ABCDEF
3. Store byte wdata 0xAA at 0x13 -> mem_read at T+1 and mem_write at T+2 with mem_address 0x10, each exactly once; response at T+3; load double at 0x10 -> 0x012345AA89ABCDEF.
4. Store half at 0x11, and load word at 0x400 -> resp_error=1, resp_rdata=0, response at T+1, no mem strobes, memory unchanged.
5. Load with resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata and resp_error stable, req_ready=0; after handshake resp_valid=0 and req_ready=1 next cycle.
6. Drive reset_n low during RMW_RD of a byte store to 0x20 -> all outputs at reset values immediately, no mem_write, memory at 0x20 unchanged; a subsequent request completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the data-memory port of the load/store unit.
// The master side is the execute stage together with the memory; the slave side is the unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;

  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_read_data;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator for a big-endian 64-bit data memory: lane extraction,
// sign/zero extension on loads and read-modify-write for sub-doubleword stores.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic              clk,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_WR,
    RMW_RD,
    RMW_WR,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] merged_q, merged_d;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [2:0]  align_bits;
  logic        req_err;
  logic [5:0]  lane_sh;
  logic [63:0] rd_top;
  logic [63:0] load_val;
  logic [63:0] field_mask;
  logic [63:0] field_data;
  logic [63:0] lane_mask;
  logic [63:0] merged;

  function automatic logic [63:0] load_extend(input logic [63:0] top,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [63:0] r;
    case (size)
      2'b00:   r = uns ? {56'h0, top[63:56]} : {{56{top[63]}}, top[63:56]};
      2'b01:   r = uns ? {48'h0, top[63:48]} : {{48{top[63]}}, top[63:48]};
      2'b10:   r = uns ? {32'h0, top[63:32]} : {{32{top[63]}}, top[63:32]};
      default: r = top;
    endcase
    return r;
  endfunction

  // Request checks are made on the live request fields in the accept cycle.
  always_comb begin
    case (bus.req_size)
      2'b00:   align_bits = 3'b000;
      2'b01:   align_bits = 3'b001;
      2'b10:   align_bits = 3'b011;
      default: align_bits = 3'b111;
    endcase
  end

  assign req_err = (|(bus.req_addr[2:0] & align_bits)) ||
                   (bus.req_addr >= 64'(MEM_BYTES));

  // Shifting left by the lane offset brings lane k to the top byte, so the
  // field is always left-justified before extension.
  assign lane_sh  = {addr_q[2:0], 3'b000};
  assign rd_top   = bus.mem_read_data << lane_sh;
  assign load_val = load_extend(rd_top, size_q, unsigned_q);

  always_comb begin
    field_mask = '0;
    field_data = '0;
    case (size_q)
      2'b00: begin
        field_mask = {8'hFF, 56'h0};
        field_data = {wdata_q[7:0], 56'h0};
      end
      2'b01: begin
        field_mask = {16'hFFFF, 48'h0};
        field_data = {wdata_q[15:0], 48'h0};
      end
      2'b10: begin
        field_mask = {32'hFFFF_FFFF, 32'h0};
        field_data = {wdata_q[31:0], 32'h0};
      end
      default: begin
        field_mask = '1;
        field_data = wdata_q;
      end
    endcase
  end

  assign lane_mask = field_mask >> lane_sh;
  assign merged    = (bus.mem_read_data & ~lane_mask) | (field_data >> lane_sh);

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    rdata_d    = rdata_q;
    error_d    = error_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d    = bus.req_store;
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          rdata_d    = '0;
          error_d    = req_err;
          if (req_err)
            state_d = RESP;
          else if (!bus.req_store)
            state_d = LOAD;
          else if (bus.req_size == 2'b11)
            state_d = STORE_WR;
          else
            state_d = RMW_RD;
        end
      end
      LOAD: begin
        rdata_d = load_val;
        state_d = RESP;
      end
      STORE_WR: state_d = RESP;
      RMW_RD: begin
        merged_d = merged;
        state_d  = RMW_WR;
      end
      RMW_WR:   state_d = RESP;
      RESP: begin
        if (bus.resp_ready)
          state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merged_q   <= merged_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  // Strobes decode straight from the state register so a reset drops them at once.
  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = (state_q == RESP);
  assign bus.resp_rdata     = store_q ? '0 : rdata_q;
  assign bus.resp_error     = error_q;
  assign bus.mem_read       = (state_q == LOAD) || (state_q == RMW_RD);
  assign bus.mem_write      = (state_q == STORE_WR) || (state_q == RMW_WR);
  assign bus.mem_address    = (bus.mem_read || bus.mem_write) ? {addr_q[63:3], 3'b000} : '0;
  assign bus.mem_write_data = (state_q == STORE_WR) ? wdata_q :
                              (state_q == RMW_WR)   ? merged_q : '0;

endmodule
